// File: rtl/altair_pkg.sv
// Shared definitions for the Altair boot path.
// Copier state encoding and system memory address width.
package altair_pkg;

    localparam int MEM_ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } copy_state_t;

endpackage

// File: rtl/rom_boot_copier.sv
// Copies a ROM image into system memory at boot or on request,
// holding the CPU in reset until the last byte has been written.
module rom_boot_copier
    import altair_pkg::*;
#(
    parameter int                        ADDR_WIDTH = 8,
    parameter int                        LENGTH     = 256,
    parameter logic [MEM_ADDR_WIDTH-1:0] DEST_BASE  = 16'h0000,
    parameter bit                        AUTO_START = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    output logic                      rom_rd,
    input  logic [7:0]                rom_data,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]                mem_data,
    output logic                      mem_we,
    input  logic                      mem_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      cpu_hold
);

    // One extra index bit lets LENGTH reach 2**ADDR_WIDTH.
    localparam int            IW   = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

    copy_state_t   state;
    logic [IW-1:0] index;
    logic [IW-1:0] index_inc;
    logic          started;
    logic          launch;

    assign index_inc = index + IW'(1);

    always_comb begin
        launch = 1'b0;
        if (state == IDLE) begin
            launch = start || (AUTO_START && !started);
        end else if (state == DONE) begin
            launch = start;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            started  <= 1'b0;
            rom_addr <= '0;
            rom_rd   <= 1'b0;
            mem_addr <= DEST_BASE;
            mem_data <= '0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        started  <= 1'b1;
                        index    <= '0;
                        rom_addr <= '0;
                        rom_rd   <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    rom_rd <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    mem_data <= rom_data;
                    mem_addr <= DEST_BASE + MEM_ADDR_WIDTH'(index);
                    mem_we   <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (index == LAST) begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= DONE;
                        end else begin
                            index    <= index_inc;
                            rom_addr <= index_inc[ADDR_WIDTH-1:0];
                            rom_rd   <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_boot_copier.sv
// Self-checking bench: two copier instances against a simple
// "byte i of ROM lands at DEST_BASE+i" reference.
module tb_rom_boot_copier;

    logic clk = 1'b0;
    logic reset;

    logic       start_a, ready_a;
    logic [7:0] rom_addr_a, rom_data_a, mem_data_a;
    logic       rom_rd_a, mem_we_a, busy_a, done_a, hold_a;
    logic [15:0] mem_addr_a;

    logic       start_b, ready_b;
    logic [7:0] rom_addr_b, rom_data_b, mem_data_b;
    logic       rom_rd_b, mem_we_b, busy_b, done_b, hold_b;
    logic [15:0] mem_addr_b;

    localparam int          LEN_A  = 4;
    localparam logic [15:0] BASE_A = 16'hFFFE;
    localparam int          LEN_B  = 256;
    localparam logic [15:0] BASE_B = 16'h0000;

    logic [7:0] rom [256];

    logic [15:0] qa_addr[$], qb_addr[$];
    logic [7:0]  qa_data[$], qb_data[$];
    logic [7:0]  rd_a[$], rd_b[$];
    int overlap = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    rom_boot_copier #(
        .ADDR_WIDTH(8), .LENGTH(LEN_A),
        .DEST_BASE(BASE_A), .AUTO_START(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .rom_addr(rom_addr_a), .rom_rd(rom_rd_a),
        .rom_data(rom_data_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .mem_we(mem_we_a),
        .mem_ready(ready_a), .busy(busy_a),
        .done(done_a), .cpu_hold(hold_a)
    );

    rom_boot_copier #(
        .ADDR_WIDTH(8), .LENGTH(LEN_B),
        .DEST_BASE(BASE_B), .AUTO_START(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .rom_addr(rom_addr_b), .rom_rd(rom_rd_b),
        .rom_data(rom_data_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .mem_we(mem_we_b),
        .mem_ready(ready_b), .busy(busy_b),
        .done(done_b), .cpu_hold(hold_b)
    );

    always #5 clk = ~clk;

    // Registered-read ROM models
    always @(posedge clk) begin
        if (rom_rd_a) rom_data_a <= rom[rom_addr_a];
        if (rom_rd_b) rom_data_b <= rom[rom_addr_b];
    end

    // Record accepted writes and ROM reads
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (mem_we_a && ready_a) begin
                qa_addr.push_back(mem_addr_a);
                qa_data.push_back(mem_data_a);
            end
            if (mem_we_b && ready_b) begin
                qb_addr.push_back(mem_addr_b);
                qb_data.push_back(mem_data_b);
            end
            if (rom_rd_a) rd_a.push_back(rom_addr_a);
            if (rom_rd_b) rd_b.push_back(rom_addr_b);
            if (rom_rd_a && mem_we_a) overlap = overlap + 1;
            if (rom_rd_b && mem_we_b) overlap = overlap + 1;
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        qa_addr.delete(); qa_data.delete(); rd_a.delete();
        qb_addr.delete(); qb_data.delete(); rd_b.delete();
    endtask

    task automatic check_copy(string tag, int sel, int len,
                              logic [15:0] base);
        int nw, nr, n;
        logic [15:0] ea;
        nw = sel ? qb_addr.size() : qa_addr.size();
        nr = sel ? rd_b.size() : rd_a.size();
        check({tag, "_nwrites"}, 32'(nw), 32'(len));
        check({tag, "_nreads"}, 32'(nr), 32'(len));
        n = (nw < len) ? nw : len;
        for (int i = 0; i < n; i++) begin
            ea = base + 16'(i);
            if (sel) begin
                check({tag, "_addr"}, 32'(qb_addr[i]), 32'(ea));
                check({tag, "_data"}, 32'(qb_data[i]), 32'(rom[i]));
            end else begin
                check({tag, "_addr"}, 32'(qa_addr[i]), 32'(ea));
                check({tag, "_data"}, 32'(qa_data[i]), 32'(rom[i]));
            end
        end
        n = (nr < len) ? nr : len;
        for (int i = 0; i < n; i++) begin
            check({tag, "_rdaddr"},
                  32'(sel ? rd_b[i] : rd_a[i]), 32'(i % 256));
        end
    endtask

    task automatic check_idle(string tag);
        check({tag, "_a_we"}, 32'(mem_we_a), 0);
        check({tag, "_a_busy"}, 32'(busy_a), 0);
        check({tag, "_a_done"}, 32'(done_a), 0);
        check({tag, "_a_hold"}, 32'(hold_a), 1);
        check({tag, "_a_rd"}, 32'(rom_rd_a), 0);
        check({tag, "_b_busy"}, 32'(busy_b), 0);
        check({tag, "_b_done"}, 32'(done_b), 0);
        check({tag, "_b_hold"}, 32'(hold_b), 1);
    endtask

    // Release reset, run both copies, check timing and contents
    task automatic run_both(string tag);
        int rel, lat_a, lat_b;
        lat_a = -1;
        lat_b = -1;
        clear_logs();
        ready_a = 1'b1;
        ready_b = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done_a && lat_a < 0) lat_a = cyc - rel;
            if (done_b && lat_b < 0) lat_b = cyc - rel;
            if (lat_a >= 0 && lat_b >= 0) break;
        end
        // First non-reset edge leaves IDLE, then 3 edges per byte
        check({tag, "_lat_a"}, 32'(lat_a), 32'(3 * LEN_A + 1));
        check({tag, "_lat_b"}, 32'(lat_b), 32'(3 * LEN_B + 1));
        check({tag, "_hold_a"}, 32'(hold_a), 0);
        check({tag, "_hold_b"}, 32'(hold_b), 0);
        check({tag, "_busy_b"}, 32'(busy_b), 0);
        repeat (3) @(negedge clk);
        check_copy({tag, "_a"}, 0, LEN_A, BASE_A);
        check_copy({tag, "_b"}, 1, LEN_B, BASE_B);
    endtask

    initial begin
        int stable, sent, found;
        rom[0] = 8'hA5;
        rom[1] = 8'h5A;
        rom[2] = 8'h00;
        rom[3] = 8'hFF;
        for (int i = 4; i < 256; i++) rom[i] = 8'($urandom);

        reset   = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_a_addr", 32'(mem_addr_a), 32'(BASE_A));
        check("reset_a_data", 32'(mem_data_a), 0);
        check("reset_a_romaddr", 32'(rom_addr_a), 0);
        start_a = 1'b0;
        start_b = 1'b0;

        // Power-up copy on both instances
        run_both("boot");

        // Re-copy from DONE with a stall on byte 1
        clear_logs();
        ready_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_done", 32'(done_a), 0);
        check("restart_hold", 32'(hold_a), 1);
        check("restart_busy", 32'(busy_a), 1);
        stable = 0;
        sent = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_a) break;
            start_a = 1'b0;
            ready_a = 1'b0;
            if (mem_we_a) begin
                if (mem_addr_a == 16'hFFFF) begin
                    stable = stable + 1;
                    check("stall_data", 32'(mem_data_a), 32'h5A);
                    ready_a = (stable >= 6);
                end else begin
                    ready_a = 1'b1;
                end
                // start during busy must be ignored
                if (mem_addr_a == 16'h0000 && sent == 0) begin
                    start_a = 1'b1;
                    sent = 1;
                end
            end
        end
        start_a = 1'b0;
        check("stall_done", 32'(done_a), 1);
        check("stall_cycles", 32'(stable), 6);
        check_copy("recopy", 0, LEN_A, BASE_A);

        // Reset during the WRITE of byte 2
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_we_a && mem_addr_a == 16'h0000) begin
                found = 1;
                break;
            end
        end
        check("abort_reached", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort");
        run_both("after_abort");

        check("rom_vs_we", 32'(overlap), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
